// File: rtl/wci_master_initiator.sv
// ---------------------------------------------------------------------------
// wci_master_initiator
//   Control-plane initiator for one WCI slave port. Takes a single host
//   request (control-op or config-property read/write), issues it as an
//   OCP-style WCI command, waits for SResp (or times out) and hands the
//   status/data back to the host. Also owns the worker reset wci_MReset_n.
//
// Ports
//   CLK, RST_N            clock, synchronous active-low reset
//   req_*                 host request (valid/ready handshake)
//   resp_*                host response (valid/ready handshake)
//   wrk_reset_req         level request to hold the worker in reset
//   attn                  SFlag[0] registered
//   wci_M*                WCI master outputs (all registered)
//   wci_S*                WCI slave inputs
//
// Parameters
//   TIMEOUT_LOG2          timeout fires 2^TIMEOUT_LOG2-1 cycles after accept
//   RESET_HOLD            cycles wci_MReset_n stays low after wrk_reset_req drops
//
// Optional build macro: WCI_MASTER_STATS_EN adds stat_txn / stat_timeouts.
// ---------------------------------------------------------------------------
module wci_master_initiator #(
  parameter int TIMEOUT_LOG2 = 16,
  parameter int RESET_HOLD   = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_space,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_status,
  input  logic        wrk_reset_req,
  output logic        attn,
  output logic [2:0]  wci_MCmd,
  output logic        wci_MAddrSpace,
  output logic [3:0]  wci_MByteEn,
  output logic [31:0] wci_MAddr,
  output logic [31:0] wci_MData,
  input  logic [1:0]  wci_SResp,
  input  logic [31:0] wci_SData,
  input  logic        wci_SThreadBusy,
  input  logic [1:0]  wci_SFlag,
  output logic [1:0]  wci_MFlag,
`ifdef WCI_MASTER_STATS_EN
  output logic [31:0] stat_txn,
  output logic [15:0] stat_timeouts,
`endif
  output logic        wci_MReset_n
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_RSTW} state_e;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;

  localparam logic [1:0] SR_NULL = 2'd0;
  localparam logic [1:0] SR_DVA  = 2'd1;
  localparam logic [1:0] SR_FAIL = 2'd2;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_FAIL    = 2'd1;
  localparam logic [1:0] ST_ERR     = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam int HOLD_W = $clog2(RESET_HOLD + 1) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD);

  localparam logic [TIMEOUT_LOG2-1:0] TO_MAX  = '1;
  // Last count value before saturation: the edge leaving it is the timeout edge.
  localparam logic [TIMEOUT_LOG2-1:0] TO_LAST = TO_MAX - TIMEOUT_LOG2'(1);

  state_e                  state_q, state_d;
  logic [2:0]              mcmd_q, mcmd_d;
  logic                    mspace_q, mspace_d;
  logic [3:0]              mbe_q, mbe_d;
  logic [31:0]             maddr_q, maddr_d;
  logic [31:0]             mdata_q, mdata_d;
  logic                    is_write_q, is_write_d;
  logic                    mflag0_q, mflag0_d;
  logic                    mreset_n_q, mreset_n_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [TIMEOUT_LOG2-1:0] to_cnt_q, to_cnt_d;
  logic                    rst_pend_q, rst_pend_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             resp_data_q, resp_data_d;
  logic [1:0]              resp_status_q, resp_status_d;
  logic                    attn_q;

  logic                    resp_hs;
  logic                    to_hit;

  // Pending worker reset also blocks new requests so it is honoured before them.
  assign req_ready = (state_q == S_IDLE) && mreset_n_q && !rst_pend_q;
  assign resp_hs   = resp_valid_q && resp_ready;
  assign to_hit    = (to_cnt_q == TO_LAST);

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    mcmd_d        = mcmd_q;
    mspace_d      = mspace_q;
    mbe_d         = mbe_q;
    maddr_d       = maddr_q;
    mdata_d       = mdata_q;
    is_write_d    = is_write_q;
    mflag0_d      = mflag0_q;
    mreset_n_d    = mreset_n_q;
    hold_d        = hold_q;
    to_cnt_d      = to_cnt_q;
    rst_pend_d    = rst_pend_q;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;

    // Worker-reset requests seen mid-transaction are remembered until IDLE.
    if (wrk_reset_req && (state_q inside {S_ISSUE, S_WAIT, S_RESP}))
      rst_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          // An accepted request wins over a same-cycle reset request.
          mcmd_d     = req_write ? CMD_WR : CMD_RD;
          mspace_d   = req_space;
          mbe_d      = req_be;
          maddr_d    = req_addr;
          mdata_d    = req_data;
          is_write_d = req_write;
          mflag0_d   = 1'b0;
          to_cnt_d   = '0;
          rst_pend_d = wrk_reset_req;
          state_d    = S_ISSUE;
        end else if (wrk_reset_req || rst_pend_q) begin
          mreset_n_d = 1'b0;
          hold_d     = HOLD_LOAD;
          rst_pend_d = 1'b0;
          state_d    = S_RSTW;
        end
      end

      S_ISSUE, S_WAIT: begin
        to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TIMEOUT_LOG2'(1);
        // SResp is only meaningful in WAIT, i.e. after the accepting edge.
        if ((state_q == S_WAIT) && (wci_SResp != SR_NULL)) begin
          resp_valid_d = 1'b1;
          case (wci_SResp)
            SR_DVA:  resp_status_d = ST_OK;
            SR_FAIL: resp_status_d = ST_FAIL;
            default: resp_status_d = ST_ERR;
          endcase
          resp_data_d = (!is_write_q && (wci_SResp == SR_DVA)) ? wci_SData : 32'd0;
          state_d     = S_RESP;
        end else if (to_hit) begin
          mcmd_d        = CMD_IDLE;
          mflag0_d      = 1'b1;
          resp_valid_d  = 1'b1;
          resp_status_d = ST_TIMEOUT;
          resp_data_d   = 32'd0;
          state_d       = S_RESP;
        end else if ((state_q == S_ISSUE) && !wci_SThreadBusy) begin
          mcmd_d  = CMD_IDLE;
          state_d = S_WAIT;
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      S_RSTW: begin
        if (wrk_reset_req) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q <= HOLD_W'(1)) begin
          mreset_n_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: state_d = S_RSTW;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= S_RSTW;
      mcmd_q        <= CMD_IDLE;
      mspace_q      <= 1'b0;
      mbe_q         <= '0;
      maddr_q       <= '0;
      mdata_q       <= '0;
      is_write_q    <= 1'b0;
      mflag0_q      <= 1'b0;
      mreset_n_q    <= 1'b0;
      hold_q        <= HOLD_LOAD;
      to_cnt_q      <= '0;
      rst_pend_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
      attn_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mcmd_q        <= mcmd_d;
      mspace_q      <= mspace_d;
      mbe_q         <= mbe_d;
      maddr_q       <= maddr_d;
      mdata_q       <= mdata_d;
      is_write_q    <= is_write_d;
      mflag0_q      <= mflag0_d;
      mreset_n_q    <= mreset_n_d;
      hold_q        <= hold_d;
      to_cnt_q      <= to_cnt_d;
      rst_pend_q    <= rst_pend_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      attn_q        <= wci_SFlag[0];
    end
  end

`ifdef WCI_MASTER_STATS_EN
  logic [31:0] stat_txn_q, stat_txn_d;
  logic [15:0] stat_to_q, stat_to_d;

  always_comb begin
    stat_txn_d = stat_txn_q;
    stat_to_d  = stat_to_q;
    if (resp_hs) begin
      if (stat_txn_q != '1) stat_txn_d = stat_txn_q + 32'd1;
      if ((resp_status_q == ST_TIMEOUT) && (stat_to_q != '1))
        stat_to_d = stat_to_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stat_txn_q <= '0;
      stat_to_q  <= '0;
    end else begin
      stat_txn_q <= stat_txn_d;
      stat_to_q  <= stat_to_d;
    end
  end

  assign stat_txn      = stat_txn_q;
  assign stat_timeouts = stat_to_q;
`else
  logic unused_resp_hs;
  assign unused_resp_hs = resp_hs;
`endif

  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign resp_status    = resp_status_q;
  assign attn           = attn_q;
  assign wci_MCmd       = mcmd_q;
  assign wci_MAddrSpace = mspace_q;
  assign wci_MByteEn    = mbe_q;
  assign wci_MAddr      = maddr_q;
  assign wci_MData      = mdata_q;
  assign wci_MFlag      = {1'b0, mflag0_q};
  assign wci_MReset_n   = mreset_n_q;

endmodule

// File: tb/tb_wci_master_initiator.sv
// ---------------------------------------------------------------------------
// tb_wci_master_initiator
//   Directed bench for wci_master_initiator (TIMEOUT_LOG2=4, RESET_HOLD=16).
//   Inputs change 1 time unit after a rising edge; outputs are checked at
//   the same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_wci_master_initiator;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        req_valid, req_ready, req_write, req_space;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_status;
  logic        wrk_reset_req, attn;
  logic [2:0]  wci_MCmd;
  logic        wci_MAddrSpace;
  logic [3:0]  wci_MByteEn;
  logic [31:0] wci_MAddr, wci_MData;
  logic [1:0]  wci_SResp;
  logic [31:0] wci_SData;
  logic        wci_SThreadBusy;
  logic [1:0]  wci_SFlag, wci_MFlag;
  logic        wci_MReset_n;
`ifdef WCI_MASTER_STATS_EN
  logic [31:0] stat_txn;
  logic [15:0] stat_timeouts;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  wci_master_initiator #(.TIMEOUT_LOG2(4), .RESET_HOLD(16)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_space(req_space), .req_addr(req_addr), .req_data(req_data),
    .req_be(req_be), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_status(resp_status),
    .wrk_reset_req(wrk_reset_req), .attn(attn),
    .wci_MCmd(wci_MCmd), .wci_MAddrSpace(wci_MAddrSpace),
    .wci_MByteEn(wci_MByteEn), .wci_MAddr(wci_MAddr), .wci_MData(wci_MData),
    .wci_SResp(wci_SResp), .wci_SData(wci_SData),
    .wci_SThreadBusy(wci_SThreadBusy), .wci_SFlag(wci_SFlag),
    .wci_MFlag(wci_MFlag),
`ifdef WCI_MASTER_STATS_EN
    .stat_txn(stat_txn), .stat_timeouts(stat_timeouts),
`endif
    .wci_MReset_n(wci_MReset_n)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present_req(input logic wr, input logic sp, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be);
    req_valid = 1'b1; req_write = wr; req_space = sp;
    req_addr = a; req_data = d; req_be = be;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("resp_valid_after_hs", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    RST_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_space = 1'b0;
    req_addr = '0; req_data = '0; req_be = '0; resp_ready = 1'b0;
    wrk_reset_req = 1'b0; wci_SResp = 2'd0; wci_SData = '0;
    wci_SThreadBusy = 1'b0; wci_SFlag = 2'd0;

    // ---- reset: 3 cycles low, then 16-cycle worker reset hold ----
    repeat (3) tick();
    check("rst_mreset_n", {31'd0, wci_MReset_n}, 32'd0);
    check("rst_mcmd", {29'd0, wci_MCmd}, 32'd0);
    check("rst_maddr", wci_MAddr, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_mflag", {30'd0, wci_MFlag}, 32'd0);
    check("rst_attn", {31'd0, attn}, 32'd0);
    RST_N = 1'b1;
    repeat (15) tick();
    check("hold15_mreset_n", {31'd0, wci_MReset_n}, 32'd0);
    check("hold15_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("hold16_mreset_n", {31'd0, wci_MReset_n}, 32'd1);
    check("hold16_req_ready", {31'd0, req_ready}, 32'd1);

    // ---- config write, DVA two cycles after accept ----
    present_req(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    tick();
    req_valid = 1'b0;
    check("wr_mcmd", {29'd0, wci_MCmd}, 32'd1);
    check("wr_maddr", wci_MAddr, 32'h0000_0010);
    check("wr_mdata", wci_MData, 32'hDEAD_BEEF);
    check("wr_mbyteen", {28'd0, wci_MByteEn}, 32'hF);
    check("wr_mspace", {31'd0, wci_MAddrSpace}, 32'd1);
    check("wr_req_ready_busy", {31'd0, req_ready}, 32'd0);
    tick();
    check("wr_mcmd_one_cycle", {29'd0, wci_MCmd}, 32'd0);
    wci_SResp = 2'd1;
    tick();
    wci_SResp = 2'd0;
    check("wr_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("wr_status", {30'd0, resp_status}, 32'd0);
    check("wr_data", resp_data, 32'd0);
    check("wr_excl_ready", {31'd0, req_ready}, 32'd0);
    handshake();
    check("wr_idle_ready", {31'd0, req_ready}, 32'd1);

    // ---- config read, SThreadBusy high for 5 cycles ----
    present_req(1'b0, 1'b1, 32'h0000_0020, 32'h0, 4'h3);
    wci_SThreadBusy = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rd_busy_mcmd", {29'd0, wci_MCmd}, 32'd2);
      check("rd_busy_maddr", wci_MAddr, 32'h0000_0020);
      check("rd_busy_mbe", {28'd0, wci_MByteEn}, 32'h3);
      tick();
    end
    wci_SThreadBusy = 1'b0;
    check("rd_mcmd_cycle6", {29'd0, wci_MCmd}, 32'd2);
    tick();
    check("rd_mcmd_dropped", {29'd0, wci_MCmd}, 32'd0);
    wci_SResp = 2'd1; wci_SData = 32'h1234_5678;
    tick();
    wci_SResp = 2'd0; wci_SData = '0;
    check("rd_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("rd_data", resp_data, 32'h1234_5678);
    check("rd_status", {30'd0, resp_status}, 32'd0);
    handshake();

    // ---- timeout: no response ever ----
    present_req(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    repeat (14) tick();
    check("to_not_yet", {31'd0, resp_valid}, 32'd0);
    check("to_mcmd_held", {29'd0, wci_MCmd}, 32'd0);
    tick();
    check("to_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("to_status", {30'd0, resp_status}, 32'd3);
    check("to_data", resp_data, 32'd0);
    check("to_mflag", {30'd0, wci_MFlag}, 32'd1);
    wci_SResp = 2'd1; wci_SData = 32'hFFFF_0000;
    tick();
    wci_SResp = 2'd0;
    check("to_late_status", {30'd0, resp_status}, 32'd3);
    check("to_late_data", resp_data, 32'd0);
    handshake();
    wci_SResp = 2'd1;
    tick();
    wci_SResp = 2'd0;
    check("to_late_idle", {31'd0, resp_valid}, 32'd0);
    check("to_mflag_sticky", {30'd0, wci_MFlag}, 32'd1);

    // ---- FAIL read; SResp on the accepting edge is ignored ----
    present_req(1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    check("fail_mflag_cleared", {30'd0, wci_MFlag}, 32'd0);
    wci_SResp = 2'd1; wci_SData = 32'hAAAA_AAAA;
    tick();
    check("fail_accept_edge_ignored", {31'd0, resp_valid}, 32'd0);
    wci_SResp = 2'd2; wci_SData = 32'h5555_5555;
    tick();
    wci_SResp = 2'd0;
    for (int i = 0; i < 4; i++) begin
      check("fail_hold_valid", {31'd0, resp_valid}, 32'd1);
      check("fail_hold_status", {30'd0, resp_status}, 32'd1);
      check("fail_hold_data", resp_data, 32'd0);
      tick();
    end
    handshake();

    // ---- ERR read ----
    present_req(1'b0, 1'b0, 32'h0000_0048, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    wci_SResp = 2'd3; wci_SData = 32'h7777_7777;
    tick();
    wci_SResp = 2'd0;
    check("err_status", {30'd0, resp_status}, 32'd2);
    check("err_data", resp_data, 32'd0);
    handshake();

    // ---- attn follows SFlag[0] one cycle later ----
    wci_SFlag = 2'b01;
    tick();
    check("attn_high", {31'd0, attn}, 32'd1);
    wci_SFlag = 2'b10;
    tick();
    check("attn_ignores_bit1", {31'd0, attn}, 32'd0);
    wci_SFlag = 2'b00;

    // ---- worker reset pulsed during WAIT is deferred ----
    present_req(1'b0, 1'b0, 32'h0000_0050, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    wrk_reset_req = 1'b1;
    tick();
    wrk_reset_req = 1'b0;
    check("wrst_deferred_wait", {31'd0, wci_MReset_n}, 32'd1);
    wci_SResp = 2'd1; wci_SData = 32'h0000_CAFE;
    tick();
    wci_SResp = 2'd0;
    check("wrst_resp_data", resp_data, 32'h0000_CAFE);
    check("wrst_deferred_resp", {31'd0, wci_MReset_n}, 32'd1);
    handshake();
    check("wrst_ready_blocked", {31'd0, req_ready}, 32'd0);
    tick();
    check("wrst_asserted", {31'd0, wci_MReset_n}, 32'd0);
    repeat (15) tick();
    check("wrst_hold15", {31'd0, wci_MReset_n}, 32'd0);
    tick();
    check("wrst_released", {31'd0, wci_MReset_n}, 32'd1);
    check("wrst_ready", {31'd0, req_ready}, 32'd1);

    // ---- RST_N during WAIT abandons the transaction ----
    present_req(1'b0, 1'b0, 32'h0000_0060, 32'h0, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_mcmd", {29'd0, wci_MCmd}, 32'd0);
    check("mid_rst_mreset_n", {31'd0, wci_MReset_n}, 32'd0);
    wci_SResp = 2'd1;
    tick();
    wci_SResp = 2'd0;
    check("mid_rst_late_resp", {31'd0, resp_valid}, 32'd0);
    begin
      int n;
      n = 0;
      while (!req_ready && n < 40) begin
        tick();
        n++;
      end
      // One edge already consumed above, so 15 more reach the release.
      check("mid_rst_release_cycles", n, 15);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
